if_id_reg: RTL and testbench

IF_ID_REG -- requirements
Module: if_id_reg

---
 rtl/if_id_reg.sv | 86 ++++++++
 tb/tb_if_id_reg.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: one-cycle fetch-to-decode slot with a hold buffer that keeps
// the fetched word stable while decode is stalled and SRAM read data moves on.
module if_id_reg #(
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic        if_pc_valid,
    input  logic [63:0] if_pc,
    input  logic [63:0] inst_sram_rdata,
    output logic        id_valid,
    output logic [63:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_misalign
);

    logic        id_valid_q, id_valid_d;
    logic [63:0] id_pc_q, id_pc_d;
    logic [31:0] hold_q, hold_d;
    logic        hold_vld_q, hold_vld_d;
    logic [31:0] sel_word;
    logic        stall_if, stall_id;
    logic        unused_stall;

    assign stall_if     = stall[1];
    assign stall_id     = stall[2];
    assign unused_stall = ^{stall[5:3], stall[0]};

    // SRAM returns a 64-bit beat; id_pc[2] picks the 32-bit instruction within it.
    assign sel_word = id_pc_q[2] ? inst_sram_rdata[63:32] : inst_sram_rdata[31:0];

    always_comb begin
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        if (flush) begin
            id_valid_d = 1'b0;
            hold_d     = 32'h0;
            hold_vld_d = 1'b0;
        end else if (stall_if && !stall_id) begin
            id_valid_d = 1'b0;
            hold_d     = 32'h0;
            hold_vld_d = 1'b0;
        end else if (!stall_if) begin
            id_pc_d    = if_pc;
            id_valid_d = if_pc_valid;
            hold_d     = 32'h0;
            hold_vld_d = 1'b0;
        end else if (!hold_vld_q && id_valid_q) begin
            // First held cycle: freeze the word before SRAM data changes underneath us.
            hold_d     = sel_word;
            hold_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid_q <= 1'b0;
            id_pc_q    <= 64'h0;
            hold_q     <= 32'h0;
            hold_vld_q <= 1'b0;
        end else begin
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
        end
    end

    always_comb begin
        id_inst = sel_word;
        if (!id_valid_q) begin
            id_inst = NOP_INST;
        end else if (hold_vld_q) begin
            id_inst = hold_q;
        end
    end

    assign id_valid    = id_valid_q;
    assign id_pc       = id_pc_q;
    assign id_misalign = id_valid_q && (id_pc_q[1:0] != 2'b00);

endmodule

// File: tb/tb_if_id_reg.sv
// Scoreboarded bench for if_id_reg: expected decode-slot contents are queued as each
// edge's stimulus is applied and compared one edge later.
module tb_if_id_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic        vld;
        logic [63:0] pc;
        logic [31:0] inst;
        logic        mis;
    } obs_t;

    typedef struct packed {
        logic [5:0]  stall;
        logic        flush;
        logic        pcv;
        logic [63:0] pc;
        logic [63:0] rdata;
        obs_t        exp;
    } stim_t;

    logic        clk;
    logic        rst_n;
    logic [5:0]  stall;
    logic        flush;
    logic        if_pc_valid;
    logic [63:0] if_pc;
    logic [63:0] inst_sram_rdata;
    logic        id_valid;
    logic [63:0] id_pc;
    logic [31:0] id_inst;
    logic        id_misalign;

    obs_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_fails  = 0;

    if_id_reg #(.NOP_INST(NOP)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .flush           (flush),
        .if_pc_valid     (if_pc_valid),
        .if_pc           (if_pc),
        .inst_sram_rdata (inst_sram_rdata),
        .id_valid        (id_valid),
        .id_pc           (id_pc),
        .id_inst         (id_inst),
        .id_misalign     (id_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t mk(input logic v, input logic [63:0] pc,
                                input logic [31:0] inst, input logic mis);
        obs_t o;
        o.vld  = v;
        o.pc   = pc;
        o.inst = inst;
        o.mis  = mis;
        return o;
    endfunction

    function automatic stim_t row(input logic [5:0] st, input logic fl, input logic pcv,
                                  input logic [63:0] pc, input logic [63:0] rd, input obs_t e);
        stim_t s;
        s.stall = st;
        s.flush = fl;
        s.pcv   = pcv;
        s.pc    = pc;
        s.rdata = rd;
        s.exp   = e;
        return s;
    endfunction

    function automatic obs_t cur();
        return mk(id_valid, id_pc, id_inst, id_misalign);
    endfunction

    // Apply one row at the falling edge and queue what the slot must show after the next rise.
    task automatic apply(input stim_t s, input string nm);
        @(negedge clk);
        stall           = s.stall;
        flush           = s.flush;
        if_pc_valid     = s.pcv;
        if_pc           = s.pc;
        inst_sram_rdata = s.rdata;
        exp_q.push_back(s.exp);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t g;
        rst_n = 1'b0; stall = 6'h0; flush = 1'b0; if_pc_valid = 1'b1;
        if_pc = 64'h8000_0000; inst_sram_rdata = 64'hDEAD_BEEF_CAFE_F00D;
        #2;
        exp_q.push_back(mk(1'b0, 64'h0, NOP, 1'b0)); name_q.push_back("reset_no_clk");
        g = cur();
        n_checks++;
        if (g !== exp_q.pop_front())
            begin n_fails++; $display("FAIL %s got=%h", name_q.pop_front(), g); end
        else void'(name_q.pop_front());
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(mk(1'b0, 64'h0, NOP, 1'b0)); name_q.push_back("reset_clocked");
        g = cur();
        n_checks++;
        if (g !== exp_q.pop_front())
            begin n_fails++; $display("FAIL %s got=%h", name_q.pop_front(), g); end
        else void'(name_q.pop_front());
        n_checks++;
        if (dut.hold_vld_q !== 1'b0 || dut.hold_q !== 32'h0) begin
            n_fails++;
            $display("FAIL reset_hold got vld=%b buf=%h want 0/0", dut.hold_vld_q, dut.hold_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_rows(input stim_t t[], input string nm);
        obs_t g, e;
        string n;
        foreach (t[i]) begin
            apply(t[i], $sformatf("%s_%0d", nm, i));
            g = cur();
            e = exp_q.pop_front();
            n = name_q.pop_front();
            n_checks++;
            if (g !== e) begin
                n_fails++;
                $display("FAIL %s got v=%b pc=%h inst=%h mis=%b want v=%b pc=%h inst=%h mis=%b",
                         n, g.vld, g.pc, g.inst, g.mis, e.vld, e.pc, e.inst, e.mis);
            end
        end
    endtask

    task automatic test_straight();
        stim_t t[] = new[2];
        t[0] = row(6'b0, 0, 1, 64'h8000_0000, 64'hAAAA_BBBB_1111_2222,
                   mk(1, 64'h8000_0000, 32'h1111_2222, 0));
        t[1] = row(6'b0, 0, 1, 64'h8000_0004, 64'hAAAA_BBBB_1111_2222,
                   mk(1, 64'h8000_0004, 32'hAAAA_BBBB, 0));
        run_rows(t, "straight");
    endtask

    task automatic test_stall_hold();
        stim_t t[] = new[4];
        t[0] = row(6'b000111, 0, 1, 64'h8000_0008, 64'hAAAA_BBBB_1111_2222,
                   mk(1, 64'h8000_0004, 32'hAAAA_BBBB, 0));
        t[1] = row(6'b000111, 0, 1, 64'h8000_0008, 64'h0,
                   mk(1, 64'h8000_0004, 32'hAAAA_BBBB, 0));
        t[2] = row(6'b000111, 0, 1, 64'h8000_0008, 64'h0,
                   mk(1, 64'h8000_0004, 32'hAAAA_BBBB, 0));
        t[3] = row(6'b0, 0, 1, 64'h8000_0008, 64'h2222_3333_4444_5555,
                   mk(1, 64'h8000_0008, 32'h4444_5555, 0));
        run_rows(t, "stall");
    endtask

    task automatic test_bubble();
        stim_t t[] = new[2];
        t[0] = row(6'b000011, 0, 1, 64'h8000_000C, 64'h2222_3333_4444_5555,
                   mk(0, 64'h8000_0008, NOP, 0));
        t[1] = row(6'b0, 0, 1, 64'h8000_000C, 64'h2222_3333_4444_5555,
                   mk(1, 64'h8000_000C, 32'h2222_3333, 0));
        run_rows(t, "bubble");
    endtask

    task automatic test_flush_stall();
        stim_t a[] = new[2];
        stim_t b[] = new[1];
        a[0] = row(6'b000111, 0, 1, 64'h8000_0010, 64'h2222_3333_4444_5555,
                   mk(1, 64'h8000_000C, 32'h2222_3333, 0));
        a[1] = row(6'b000111, 1, 1, 64'h8000_0010, 64'h2222_3333_4444_5555,
                   mk(0, 64'h8000_000C, NOP, 0));
        run_rows(a, "flush");
        n_checks++;
        if (dut.hold_vld_q !== 1'b0) begin
            n_fails++;
            $display("FAIL flush_hold_vld got=%b want=0", dut.hold_vld_q);
        end
        b[0] = row(6'b0, 0, 1, 64'h8000_0100, 64'h2222_3333_4444_5555,
                   mk(1, 64'h8000_0100, 32'h4444_5555, 0));
        run_rows(b, "flush_target");
    endtask

    task automatic test_misalign();
        stim_t t[] = new[2];
        t[0] = row(6'b0, 0, 1, 64'h8000_0002, 64'h2222_3333_4444_5555,
                   mk(1, 64'h8000_0002, 32'h4444_5555, 1));
        t[1] = row(6'b0, 0, 0, 64'h8000_0002, 64'h2222_3333_4444_5555,
                   mk(0, 64'h8000_0002, NOP, 0));
        run_rows(t, "misalign");
    endtask

    task automatic test_async_reset();
        stim_t a[] = new[2];
        stim_t b[] = new[1];
        stim_t c[] = new[1];
        obs_t  g;
        a[0] = row(6'b0, 0, 1, 64'h8000_0004, 64'h2222_3333_4444_5555,
                   mk(1, 64'h8000_0004, 32'h2222_3333, 0));
        a[1] = row(6'b000111, 0, 1, 64'h8000_0008, 64'h2222_3333_4444_5555,
                   mk(1, 64'h8000_0004, 32'h2222_3333, 0));
        run_rows(a, "areset_pre");
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(mk(0, 64'h0, NOP, 0)); name_q.push_back("areset_immediate");
        g = cur();
        n_checks++;
        if (g !== exp_q.pop_front()) begin
            n_fails++;
            $display("FAIL %s got=%h", name_q.pop_front(), g);
        end else void'(name_q.pop_front());
        n_checks++;
        if (dut.hold_vld_q !== 1'b0) begin
            n_fails++;
            $display("FAIL areset_hold_vld got=%b want=0", dut.hold_vld_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
        b[0] = row(6'b000111, 0, 1, 64'h8000_0008, 64'h2222_3333_4444_5555,
                   mk(0, 64'h0, NOP, 0));
        run_rows(b, "areset_still_stalled");
        n_checks++;
        if (dut.hold_vld_q !== 1'b0) begin
            n_fails++;
            $display("FAIL areset_residual_hold got=%b want=0", dut.hold_vld_q);
        end
        c[0] = row(6'b0, 0, 1, 64'h8000_0010, 64'h2222_3333_4444_5555,
                   mk(1, 64'h8000_0010, 32'h4444_5555, 0));
        run_rows(c, "areset_first_advance");
    endtask

    initial begin
        test_reset();
        test_straight();
        test_stall_hold();
        test_bubble();
        test_flush_stall();
        test_misalign();
        test_async_reset();
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
